// File: rtl/rv32i_pkg.sv
// Shared rv32i core definitions: fetch FSM states, fetch fault codes and the canonical NOP.
package rv32i_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } fetch_state_e;

  localparam logic [1:0] FETCH_OK       = 2'd0;
  localparam logic [1:0] FETCH_MISALIGN = 2'd1;
  localparam logic [1:0] FETCH_TIMEOUT  = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch_port.sv
// Fetch stage: reads the word at the current PC over a req/gnt + rvalid bus and hands it to
// decode on valid/ready, with flush, misaligned-PC and bus-timeout handling.
module instruction_fetch_port
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = RV32I_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic        fetch_start,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic [1:0]  fetch_fault,
  output logic        busy
);

  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  logic             start_ok;
  logic             misaligned;

  // >= rather than == so a flush that lands on the last WAIT cycle still times out in DRAIN.
  assign timed_out  = (wait_cnt >= CNT_LAST);
  assign start_ok   = fetch_start && !flush;
  assign misaligned = (pc[1:0] != 2'b00);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start_ok) state_nxt = misaligned ? ST_HOLD : ST_REQ;
      ST_REQ: begin
        if (imem_gnt)   state_nxt = flush ? ST_DRAIN : ST_WAIT;
        else if (flush) state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (imem_rvalid)    state_nxt = flush ? ST_IDLE : ST_HOLD;
        else if (flush)     state_nxt = ST_DRAIN;
        else if (timed_out) state_nxt = ST_HOLD;
      end
      ST_DRAIN: if (imem_rvalid || timed_out) state_nxt = ST_IDLE;
      ST_HOLD:  if (flush || instr_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered straight from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      imem_req       <= 1'b0;
      imem_addr      <= '0;
      instr_valid    <= 1'b0;
      instr          <= NOP_INSTR;
      instr_pc       <= '0;
      instr_pc_plus4 <= 32'd4;
      fetch_fault    <= FETCH_OK;
      busy           <= 1'b0;
      wait_cnt       <= '0;
    end else begin
      state       <= state_nxt;
      imem_req    <= (state_nxt == ST_REQ);
      instr_valid <= (state_nxt == ST_HOLD);
      busy        <= (state_nxt != ST_IDLE);

      if (state == ST_REQ) begin
        wait_cnt <= '0;
      end else if ((state == ST_WAIT || state == ST_DRAIN) && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (state == ST_IDLE && start_ok) begin
        instr_pc       <= pc;
        instr_pc_plus4 <= pc_plus4;
        if (misaligned) begin
          instr       <= NOP_INSTR;
          fetch_fault <= FETCH_MISALIGN;
        end else begin
          imem_addr   <= {pc[31:2], 2'b00};
          fetch_fault <= FETCH_OK;
        end
      end

      if (state == ST_WAIT && !flush) begin
        if (imem_rvalid) begin
          instr       <= imem_rdata;
          fetch_fault <= FETCH_OK;
        end else if (timed_out) begin
          instr       <= NOP_INSTR;
          fetch_fault <= FETCH_TIMEOUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_port.sv
// Randomized transaction-level bench for instruction_fetch_port; expected timelines are derived
// from the fetch rules (request, grant delay, response delay, flush point, backpressure).
module tb_instruction_fetch_port;

  localparam int          TO  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int K_NORMAL      = 0;
  localparam int K_MISALIGN    = 1;
  localparam int K_TIMEOUT     = 2;
  localparam int K_FLUSH_REQ   = 3;
  localparam int K_FLUSH_GNT   = 4;
  localparam int K_FLUSH_WAIT  = 5;
  localparam int K_FLUSH_RV    = 6;
  localparam int K_FLUSH_HOLD  = 7;
  localparam int K_FLUSH_START = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] pc_plus4 = 32'd4;
  logic        fetch_start = 1'b0;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic [1:0]  fetch_fault;
  logic        busy;

  int checks = 0;
  int errors = 0;

  instruction_fetch_port #(
    .TIMEOUT_CYCLES(TO),
    .NOP_INSTR     (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_start   (fetch_start),
    .flush         (flush),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pc_plus4(instr_pc_plus4),
    .fetch_fault   (fetch_fault),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " req"},   32'(imem_req), 32'd0);
    check_output({tag, " addr"},  imem_addr, 32'd0);
    check_output({tag, " valid"}, 32'(instr_valid), 32'd0);
    check_output({tag, " instr"}, instr, NOP);
    check_output({tag, " pc"},    instr_pc, 32'd0);
    check_output({tag, " pc4"},   instr_pc_plus4, 32'd4);
    check_output({tag, " fault"}, 32'(fetch_fault), 32'd0);
    check_output({tag, " busy"},  32'(busy), 32'd0);
  endtask

  // One fetch transaction starting at relative cycle 0. g = grant delay after the request rises,
  // d = WAIT cycle (1-based) carrying rvalid, r = cycles of backpressure once the word is held.
  task automatic apply_stimulus(input int kind, input int g_in, input int d_in, input int r,
                                input logic [31:0] pc_in, input logic [31:0] data);
    bit          fs_a [64];
    bit          fl_a [64];
    bit          gnt_a[64];
    bit          rv_a [64];
    bit          rdy_a[64];
    bit          ereq [64];
    bit          evld [64];
    bit          ebsy [64];
    logic [31:0] tpc;
    logic [31:0] exp_instr;
    logic [1:0]  exp_fault;
    int          g, d, w, v, last, k;

    for (int i = 0; i < 64; i++) begin
      fs_a[i] = 0; fl_a[i] = 0; gnt_a[i] = 0; rv_a[i] = 0; rdy_a[i] = 0;
      ereq[i] = 0; evld[i] = 0; ebsy[i] = 0;
    end
    g = g_in;
    d = d_in;
    if (kind == K_FLUSH_REQ && g < 1) g = 1;
    if (kind == K_FLUSH_WAIT && d < 2) d = 2;
    tpc = pc_in;
    if (kind == K_MISALIGN) begin
      if (tpc[1:0] == 2'b00) tpc[1:0] = 2'b10;
    end else begin
      tpc[1:0] = 2'b00;
    end
    exp_instr = data;
    exp_fault = 2'd0;
    v = -1;
    last = 1;
    w = 2 + g;
    fs_a[0] = 1;

    if (kind != K_MISALIGN && kind != K_FLUSH_START && kind != K_FLUSH_REQ) begin
      for (int t = 1; t <= 1 + g; t++) ereq[t] = 1;
      gnt_a[1 + g] = 1;
    end

    case (kind)
      K_MISALIGN: begin
        v = 1; exp_instr = NOP; exp_fault = 2'd1;
      end
      K_FLUSH_START: begin
        fl_a[0] = 1; last = 1;
      end
      K_FLUSH_REQ: begin
        k = $urandom_range(0, g - 1);
        for (int t = 1; t <= 1 + k; t++) ereq[t] = 1;
        fl_a[1 + k] = 1;
        last = 2 + k;
      end
      K_TIMEOUT: begin
        v = w + TO; exp_instr = NOP; exp_fault = 2'd2;
        if ($urandom_range(0, 1) == 1) rv_a[w + TO] = 1;
      end
      K_FLUSH_GNT: begin
        fl_a[1 + g] = 1;
        for (int t = w; t < w + d; t++) fl_a[t] = 1'($urandom_range(0, 1));
        rv_a[w + d - 1] = 1;
        last = w + d;
      end
      K_FLUSH_WAIT: begin
        k = $urandom_range(0, d - 2);
        fl_a[w + k] = 1;
        for (int t = w + k + 1; t < w + d; t++) fl_a[t] = 1'($urandom_range(0, 1));
        rv_a[w + d - 1] = 1;
        last = w + d;
      end
      K_FLUSH_RV: begin
        fl_a[w + d - 1] = 1; rv_a[w + d - 1] = 1;
        last = w + d;
      end
      default: begin
        rv_a[w + d - 1] = 1; v = w + d;
      end
    endcase

    if (v >= 0) begin
      for (int t = v; t <= v + r; t++) evld[t] = 1;
      if (kind == K_FLUSH_HOLD) begin
        fl_a[v + r] = 1;
        rdy_a[v + r] = 1'($urandom_range(0, 1));
      end else begin
        rdy_a[v + r] = 1;
      end
      last = v + r + 1;
    end
    for (int t = 1; t < last; t++) ebsy[t] = 1;

    for (int t = 0; t < last; t++) begin
      @(negedge clk);
      check_output("req",   32'(imem_req),    32'(ereq[t]));
      check_output("valid", 32'(instr_valid), 32'(evld[t]));
      check_output("busy",  32'(busy),        32'(ebsy[t]));
      if (ereq[t]) check_output("addr", imem_addr, {tpc[31:2], 2'b00});
      if (evld[t]) begin
        check_output("instr", instr, exp_instr);
        check_output("ipc",   instr_pc, tpc);
        check_output("ipc4",  instr_pc_plus4, tpc + 32'd4);
        check_output("fault", 32'(fetch_fault), 32'(exp_fault));
      end
      fetch_start = fs_a[t];
      pc          = (t == 0) ? tpc : $urandom;
      pc_plus4    = pc + 32'd4;
      flush       = fl_a[t];
      imem_gnt    = gnt_a[t];
      imem_rvalid = rv_a[t] | ((t == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      imem_rdata  = rv_a[t] ? data : $urandom;
      instr_ready = rdy_a[t] | (!evld[t] && $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic reset_mid_req();
    @(negedge clk);
    fetch_start = 1'b1; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
    pc = 32'h0000_2000; pc_plus4 = 32'h0000_2004;
    @(negedge clk);
    check_output("rst req before", 32'(imem_req), 32'd1);
    fetch_start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("rst mid");
    for (int i = 0; i < 2; i++) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
      @(negedge clk);
      check_output("late rv valid", 32'(instr_valid), 32'd0);
      check_output("late rv busy",  32'(busy), 32'd0);
    end
    imem_rvalid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    apply_stimulus(K_NORMAL,     0, 1, 5, 32'h0000_0100, 32'h0050_0093);
    apply_stimulus(K_MISALIGN,   0, 1, 0, 32'h0000_0102, 32'h1234_5678);
    apply_stimulus(K_FLUSH_WAIT, 0, 3, 0, 32'h0000_0200, 32'hDEAD_BEEF);
    apply_stimulus(K_TIMEOUT,    0, 1, 1, 32'h0000_0300, 32'h0BAD_F00D);
    apply_stimulus(K_FLUSH_START,0, 1, 0, 32'h0000_0400, 32'h0);

    for (int n = 0; n < 80; n++) begin
      apply_stimulus($urandom_range(0, 8), $urandom_range(0, 2), $urandom_range(1, TO),
                     $urandom_range(0, 5), $urandom, $urandom);
    end

    @(negedge clk);
    check_output("final valid", 32'(instr_valid), 32'd0);
    check_output("final busy",  32'(busy), 32'd0);
    fetch_start = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;

    reset_mid_req();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
